// File: rtl/raizing_rom_slot_arbiter.sv
// Round-robin ROM read arbiter: several read-only slots, each with a one-word
// tagged cache, share one SDRAM bank port with at most one fetch outstanding.
module raizing_rom_slot_arbiter #(
  parameter int CHANNELS = 3,
  parameter int AW       = 22,
  parameter int DW       = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [CHANNELS-1:0]    SLOT_CS,
  input  logic [CHANNELS*AW-1:0] SLOT_ADDR,
  input  logic [CHANNELS*22-1:0] SLOT_BASE,
  output logic [CHANNELS-1:0]    SLOT_OK,
  output logic [CHANNELS*DW-1:0] SLOT_DOUT,
  output logic [21:0]            BA_ADDR,
  output logic                   BA_RD,
  input  logic                   BA_ACK,
  input  logic                   BA_RDY,
  input  logic [15:0]            BA_DATA
);
  localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t              state, state_next;
  logic [PW-1:0]       grant, grant_next, ptr, ptr_next, ptr_adv, pick;
  logic [21:0]         lat_wa, lat_wa_next, ba_addr_next;
  logic [15:0]         cache_data [CHANNELS];
  logic [21:0]         cache_tag  [CHANNELS];
  logic [CHANNELS-1:0] cache_valid;
  logic [21:0]         wa         [CHANNELS];
  logic [CHANNELS-1:0] miss, ok_next;
  logic                fill;
  int                  idx;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_slot
    logic [22:0] addr_ext;
    if (AW >= 23) begin : g_wide
      assign addr_ext = SLOT_ADDR[i*AW +: 23];
    end else begin : g_narrow
      assign addr_ext = {{(23-AW){1'b0}}, SLOT_ADDR[i*AW +: AW]};
    end
    // Byte slots drop the byte-select bit to form the word address.
    if (DW == 16) begin : g_word
      assign wa[i]                  = addr_ext[21:0];
      assign SLOT_DOUT[i*DW +: DW]  = cache_data[i];
    end else begin : g_byte
      assign wa[i]                  = addr_ext[22:1];
      assign SLOT_DOUT[i*DW +: DW]  = addr_ext[0] ? cache_data[i][15:8] : cache_data[i][7:0];
    end
    assign miss[i] = SLOT_CS[i] & ~(cache_valid[i] & (cache_tag[i] == wa[i]));
  end

  assign ptr_adv = (int'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;

  // Round-robin pick: scan downwards so the first miss at or after ptr wins.
  always_comb begin
    pick = '0;
    idx  = 0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx  = (int'(ptr) + k >= CHANNELS) ? int'(ptr) + k - CHANNELS : int'(ptr) + k;
      pick = miss[idx] ? PW'(idx) : pick;
    end
  end

  // Fetch sequencer: next state, latched request and fill strobe.
  always_comb begin
    state_next   = state;
    grant_next   = grant;
    lat_wa_next  = lat_wa;
    ba_addr_next = BA_ADDR;
    ptr_next     = ptr;
    fill         = 1'b0;
    case (state)
      IDLE: begin
        if (|miss) begin
          state_next   = REQ;
          grant_next   = pick;
          lat_wa_next  = wa[pick];
          ba_addr_next = wa[pick] + SLOT_BASE[int'(pick)*22 +: 22];
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        if (BA_ACK && BA_RDY) begin
          fill       = 1'b1;
          state_next = IDLE;
          ptr_next   = ptr_adv;
        end else if (BA_ACK) begin
          state_next = WAIT;
        end else begin
          state_next = REQ;
        end
      end
      WAIT: begin
        if (BA_RDY) begin
          fill       = 1'b1;
          state_next = IDLE;
          ptr_next   = ptr_adv;
        end else begin
          state_next = WAIT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // OK is judged against the cache as it will look after this edge's fill.
  always_comb begin
    ok_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (fill && (grant == PW'(i))) begin
        ok_next[i] = SLOT_CS[i] & (lat_wa == wa[i]);
      end else begin
        ok_next[i] = SLOT_CS[i] & ~miss[i];
      end
    end
  end

  // State, request and cache registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      grant       <= '0;
      ptr         <= '0;
      lat_wa      <= 22'd0;
      BA_ADDR     <= 22'd0;
      BA_RD       <= 1'b0;
      SLOT_OK     <= '0;
      cache_valid <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cache_data[i] <= 16'd0;
        cache_tag[i]  <= 22'd0;
      end
    end else begin
      state   <= state_next;
      grant   <= grant_next;
      ptr     <= ptr_next;
      lat_wa  <= lat_wa_next;
      BA_ADDR <= ba_addr_next;
      BA_RD   <= (state_next == REQ);
      SLOT_OK <= ok_next;
      if (fill) begin
        cache_data[grant]  <= BA_DATA;
        cache_tag[grant]   <= lat_wa;
        cache_valid[grant] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_raizing_rom_slot_arbiter.sv
// Bench for raizing_rom_slot_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a transaction-level cache/arbiter model.
module tb_raizing_rom_slot_arbiter;
  localparam int C = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [C-1:0]    cs   = '0;
  logic [C*22-1:0] addr = '0;
  logic [C*22-1:0] base = '0;
  logic [C-1:0]    ok;
  logic [C*8-1:0]  dout;
  logic [21:0]     ba_addr;
  logic            ba_rd;
  logic            ba_ack  = 1'b0;
  logic            ba_rdy  = 1'b0;
  logic [15:0]     ba_data = 16'd0;

  logic [4:0]      d_cs   = '0;
  logic [109:0]    d_addr = '0;
  logic [109:0]    d_base = '0;
  logic [4:0]      d_ok;
  logic [79:0]     d_dout;
  logic [21:0]     d_ba_addr;
  logic            d_rd;
  logic            d_ack  = 1'b0;
  logic            d_rdy  = 1'b0;
  logic [15:0]     d_data = 16'd0;

  raizing_rom_slot_arbiter #(.CHANNELS(C), .AW(22), .DW(8)) dut (
    .CLK(clk), .RESET(rst), .SLOT_CS(cs), .SLOT_ADDR(addr), .SLOT_BASE(base),
    .SLOT_OK(ok), .SLOT_DOUT(dout), .BA_ADDR(ba_addr), .BA_RD(ba_rd),
    .BA_ACK(ba_ack), .BA_RDY(ba_rdy), .BA_DATA(ba_data)
  );

  raizing_rom_slot_arbiter #(.CHANNELS(5), .AW(22), .DW(16)) dut16 (
    .CLK(clk), .RESET(rst), .SLOT_CS(d_cs), .SLOT_ADDR(d_addr), .SLOT_BASE(d_base),
    .SLOT_OK(d_ok), .SLOT_DOUT(d_dout), .BA_ADDR(d_ba_addr), .BA_RD(d_rd),
    .BA_ACK(d_ack), .BA_RDY(d_rdy), .BA_DATA(d_data)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: per-slot word cache, pointer, and the one outstanding fetch.
  bit          m_valid [C];
  logic [21:0] m_tag   [C];
  logic [15:0] m_data  [C];
  int          m_ptr, m_phase, m_g;
  logic [21:0] m_wa, m_addr;
  bit          exp_ok  [C];
  int          seen_slot[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] wa_of(input int i);
    return 22'(addr[i*22 +: 22] >> 1);
  endfunction

  function automatic bit hit(input int i);
    return m_valid[i] && (m_tag[i] == wa_of(i));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < C; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 22'd0; m_data[i] = 16'd0; exp_ok[i] = 1'b0;
    end
    m_ptr = 0; m_phase = 0; m_g = 0;
  endtask

  // One clock: drive the bank response, advance the model, then compare.
  task automatic step(input bit ack, input bit rdy, input logic [15:0] data);
    bit fill, found, newreq;
    int s;
    ba_ack = ack; ba_rdy = rdy; ba_data = data;
    fill   = (m_phase == 1 && ack && rdy) || (m_phase == 2 && rdy);
    newreq = 1'b0;
    if (fill) begin
      m_valid[m_g] = 1'b1; m_tag[m_g] = m_wa; m_data[m_g] = data;
      m_ptr = (m_g + 1) % C; m_phase = 0;
    end else if (m_phase == 1 && ack) begin
      m_phase = 2;
    end else if (m_phase == 0) begin
      found = 1'b0;
      for (int k = 0; k < C; k++) begin
        s = (m_ptr + k) % C;
        if (!found && cs[s] && !hit(s)) begin found = 1'b1; m_g = s; end
      end
      if (found) begin
        m_phase = 1; newreq = 1'b1;
        m_wa    = wa_of(m_g);
        m_addr  = 22'(m_wa + base[m_g*22 +: 22]);
      end
    end
    for (int i = 0; i < C; i++) exp_ok[i] = cs[i] && hit(i);
    @(posedge clk);
    @(negedge clk);
    ba_ack = 1'b0; ba_rdy = 1'b0;
    chk("ba_rd", ba_rd, m_phase == 1);
    if (m_phase == 1) chk("ba_addr", ba_addr, m_addr);
    if (newreq) seen_slot.push_back(int'(ba_addr[21:20]) - 1);
    for (int i = 0; i < C; i++) begin
      chk("slot_ok", ok[i], exp_ok[i]);
      chk("slot_dout", dout[i*8 +: 8], addr[i*22] ? m_data[i][15:8] : m_data[i][7:0]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int  s;
    bit  a, r, seen;
    int  order [6];
    order = '{0, 1, 2, 0, 1, 2};
    model_reset();
    base = {22'h300000, 22'h200000, 22'h100000};
    repeat (2) @(negedge clk);
    chk("rst_ok", ok, 0);
    chk("rst_rd", ba_rd, 0);
    chk("rst_addr", ba_addr, 0);
    chk("rst_dout", dout, 0);
    rst = 1'b0;

    // Single fetch, byte select from the cached word.
    cs[0] = 1'b1; addr[21:0] = 22'h000005;
    step(1'b0, 1'b0, 16'h0);
    chk("t1_addr", ba_addr, 22'h100002);
    step(1'b0, 1'b0, 16'h0);
    chk("t1_rd_hold", ba_rd, 1);
    step(1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'hA1B2);
    chk("t1_ok", ok[0], 1);
    chk("t1_dout_hi", dout[7:0], 8'hA1);
    addr[21:0] = 22'h000004;
    step(1'b0, 1'b0, 16'h0);
    chk("t1_dout_lo", dout[7:0], 8'hB2);
    chk("t1_no_rd", ba_rd, 0);

    // Slot 1 moves to another word while its fetch is in flight.
    cs[1] = 1'b1; addr[43:22] = 22'h000010;
    step(1'b0, 1'b0, 16'h0);
    chk("t2_addr", ba_addr, 22'h200008);
    step(1'b1, 1'b0, 16'h0);
    addr[43:22] = 22'h000020;
    step(1'b0, 1'b1, 16'h5566);
    chk("t2_ok_low", ok[1], 0);
    step(1'b0, 1'b0, 16'h0);
    chk("t2_refetch", ba_addr, 22'h200010);
    // Acknowledge and data in the same cycle.
    step(1'b1, 1'b1, 16'h1234);
    chk("t3_ok", ok[1], 1);
    chk("t3_dout", dout[15:8], 8'h34);
    chk("t3_rd_low", ba_rd, 0);
    step(1'b0, 1'b0, 16'h0);
    chk("t3_idle", ba_rd, 0);

    // Round-robin order across two rounds of simultaneous misses.
    do_reset();
    seen_slot.delete();
    cs = 3'b111;
    addr = {22'h000030, 22'h000020, 22'h000010};
    repeat (10) step(m_phase == 1, m_phase == 2, 16'($urandom));
    addr = {22'h000060, 22'h000050, 22'h000040};
    repeat (10) step(m_phase == 1, m_phase == 2, 16'($urandom));
    chk("rr_count", seen_slot.size(), 6);
    for (int i = 0; i < 6 && i < seen_slot.size(); i++) chk("rr_order", seen_slot[i], order[i]);

    // Reset while waiting for data, then a stray ready pulse.
    addr[65:44] = 22'h000100;
    cs = 3'b100;
    step(1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    cs = 3'b000;
    do_reset();
    chk("wrst_ok", ok, 0);
    chk("wrst_rd", ba_rd, 0);
    step(1'b0, 1'b1, 16'hDEAD);
    chk("wrst_dout", dout, 0);
    cs = 3'b110;
    step(1'b0, 1'b0, 16'h0);
    chk("wrst_ptr0", ba_addr, 22'h200000 + (addr[43:22] >> 1));

    // Random traffic over a small address set so hits and re-misses mix.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        s = $urandom_range(0, C - 1);
        cs[s] = ($urandom_range(0, 3) != 0);
        addr[s*22 +: 22] = 22'($urandom_range(0, 15));
      end
      a = 1'b0; r = 1'b0;
      case (m_phase)
        1:       begin a = ($urandom_range(0, 2) == 0); r = a && ($urandom_range(0, 1) == 1); end
        2:       r = ($urandom_range(0, 2) == 0);
        default: r = ($urandom_range(0, 7) == 0);
      endcase
      step(a, r, 16'($urandom));
    end

    // Word slots, five channels, bank address wraps past the top.
    d_cs = 5'b10000;
    d_addr[109:88] = 22'h3FFFFF;
    d_base[109:88] = 22'd2;
    seen = 1'b0;
    for (int n = 0; n < 6 && !seen; n++) begin
      @(negedge clk);
      seen = d_rd;
    end
    chk("d16_rd", seen, 1);
    chk("d16_addr", d_ba_addr, 22'h000001);
    d_ack = 1'b1;
    @(negedge clk);
    d_ack = 1'b0;
    chk("d16_rd_low", d_rd, 0);
    d_rdy = 1'b1; d_data = 16'hBEEF;
    @(negedge clk);
    d_rdy = 1'b0;
    chk("d16_ok", d_ok[4], 1);
    chk("d16_dout", d_dout[79:64], 16'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/raizing_rom_slot_arbiter.md
Name: raizing_rom_slot_arbiter

Overview:
Parametrised N-channel ROM read arbiter that shares one SDRAM bank port among several read-only slots, for example the three PCM streams and the two Z80 program fetchers of the sound subsystem. Each slot has a one-word cache with an address tag. Misses are serviced one at a time in round-robin order. The block sits between sound/CPU clients and the bank interface of the game's SDRAM controller.

Parameters:
CHANNELS, 3, number of client slots (1..8)
AW, 22, slot address width
DW, 8, slot data width; 8 = byte slots, 16 = word slots

Ports:
CLK  input  1  system clock; all logic on rising edge
RESET  input  1  asynchronous, active-high reset
SLOT_CS  input  CHANNELS  per-slot read request, level
SLOT_ADDR  input  CHANNELS*AW  per-slot address, slot i at [i*AW +: AW]; byte address if DW=8, word address if DW=16
SLOT_BASE  input  CHANNELS*22  per-slot word offset added to the bank address, slot i at [i*22 +: 22]
SLOT_OK  output  CHANNELS  per-slot data valid for the current address
SLOT_DOUT  output  CHANNELS*DW  per-slot read data, slot i at [i*DW +: DW]
BA_ADDR  output  22  bank word address
BA_RD  output  1  bank read request
BA_ACK  input  1  bank accepted the request
BA_RDY  input  1  BA_DATA valid this cycle
BA_DATA  input  16  bank read word

Behaviour:
- Word address per slot:
  - DW=16: WA = ADDR[21:0], zero-extended if AW<22.
  - DW=8: WA = ADDR[AW-1:1].
  - Bank address = WA + BASE, modulo 2^22.
- Per-slot cache: 16-bit data, 22-bit tag (WA before adding BASE), valid bit.
  - hit_i = valid_i & (tag_i == WA_i).
  - miss_i = CS_i & !hit_i.
- SLOT_DOUT:
  - DW=16: cache word.
  - DW=8: WA byte 0 selects data[7:0]; byte 1 selects data[15:8]. Byte select is ADDR[0], applied combinationally from the cached word.
- SLOT_OK_i is a register. Next value = CS_i & hit_i, evaluated on the post-update cache state. A fill therefore raises OK on the edge that writes the cache.
  - Hit latency: 1 cycle after CS/ADDR are stable.
  - An address change to a non-cached word drops OK on the next edge.
- FSM states:
  - IDLE: if any miss_i, grant g = first miss at or after pointer P, wrapping. Latch the grant index, the slot's WA, and BA_ADDR. Go to REQ with BA_RD=1 from the next cycle.
  - REQ: hold BA_RD=1 and BA_ADDR until BA_ACK.
    - On ACK, BA_RD=0 next cycle and go to WAIT.
    - If ACK and RDY arrive together, perform the fill immediately and go to IDLE.
  - WAIT: on BA_RDY, write BA_DATA into cache g with tag = latched WA, set valid, set P = g+1 (mod CHANNELS), go to IDLE.
- One outstanding request maximum. BA_RD is never high outside REQ.
- Address changes while slot g is being fetched:
  - The fill still writes the latched tag.
  - If the tag mismatches the new address, OK stays low and the slot re-misses next arbitration.
- CS dropped mid-fetch: the fetch completes and the cache is filled; OK stays 0 while CS=0.
- Pointer P advances only on a completed fill. Worst-case wait for any slot is CHANNELS-1 other fetches.
- CHANNELS=1: P is fixed at 0.
- Reset, asynchronous at any point including mid-fetch:
  - State IDLE, BA_RD=0, BA_ADDR=0, P=0.
  - All valid bits cleared, SLOT_OK=0.
  - Cache data = 0, so SLOT_DOUT=0.
  - A BA_RDY arriving after reset release with no request pending is ignored.
- BA_RDY in IDLE or REQ without ACK is ignored.

Test Plan:
- Single slot, default params: CS0=1, ADDR0=0x000005, BASE0=0x100000. Bank returns 0xA1B2 two cycles after ACK. Required: BA_ADDR=0x100002 with BA_RD high until ACK, OK0=1 on the fill edge, DOUT0=0xA1. Then ADDR0=0x000004 gives DOUT0=0xB2 with OK0 held high and no new BA_RD.
- Three simultaneous misses at P=0: required grant order slots 0,1,2. Repeated misses afterwards: order continues 0,1,2 (P wraps 3->0), and no slot waits more than 2 fetches.
- Slot 1 changes ADDR from 0x10 to 0x20 during WAIT: required fill tag 0x08, OK1 stays 0, and a new BA_RD with BA_ADDR=BASE1+0x10 follows.
- BA_ACK and BA_RDY high in the same cycle: required fill on that edge, BA_RD low the next cycle, FSM back in IDLE.
- Assert RESET while in WAIT, then pulse BA_RDY after release: required all OK=0, cache unchanged (valid=0), BA_RD=0, P=0.
- DW=16, CHANNELS=5, slot 4 with ADDR=0x3FFFFF and BASE=2: required BA_ADDR=0x000001 (wrap) and DOUT4 equal to the full bank word.
